// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_e;

endpackage

// File: rtl/stream_demux_if.sv
// Stream bus of the 1-to-2 demultiplexer: one upstream port, two downstream ports.
interface stream_demux_if #(
  parameter int unsigned DATA_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_sel;
  logic              in_ready;

  logic              out0_valid;
  logic [DATA_W-1:0] out0_data;
  logic              out0_last;
  logic              out0_ready;

  logic              out1_valid;
  logic [DATA_W-1:0] out1_data;
  logic              out1_last;
  logic              out1_ready;

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );

  // Source/sink side.
  modport master (
    output in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );

endinterface

// File: rtl/stream_demux_out_reg.sv
// One registered output slice: load on accept, clear valid on drain-without-load.
module stream_demux_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// Packet-locked 1-to-2 stream demux. Define STREAM_DEMUX_STATS_EN to add
// per-port handshake counters cnt0/cnt1.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  state_e state_q;
  logic   target;
  logic   tgt_valid;
  logic   tgt_ready;
  logic   accept;
  logic   load0;
  logic   load1;

  // in_sel only matters on the first beat of a packet.
  always_comb begin
    target    = (state_q == LOCK1) || ((state_q == IDLE) && bus.in_sel);
    tgt_valid = target ? bus.out1_valid : bus.out0_valid;
    tgt_ready = target ? bus.out1_ready : bus.out0_ready;
    accept    = bus.in_valid && bus.in_ready;
    load0     = accept && !target;
    load1     = accept && target;
  end

  assign bus.in_ready = !tgt_valid || tgt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (accept) begin
      unique case (state_q)
        IDLE:         if (!bus.in_last) state_q <= bus.in_sel ? LOCK1 : LOCK0;
        LOCK0, LOCK1: if (bus.in_last)  state_q <= IDLE;
        default:      state_q <= IDLE;
      endcase
    end
  end

  stream_demux_out_reg #(
    .DATA_W (DATA_W)
  ) u_out0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .ready     (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data),
    .last      (bus.out0_last)
  );

  stream_demux_out_reg #(
    .DATA_W (DATA_W)
  ) u_out1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .ready     (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data),
    .last      (bus.out1_last)
  );

`ifdef STREAM_DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (bus.out0_valid && bus.out0_ready) cnt0 <= cnt0 + CNT_W'(1);
      if (bus.out1_valid && bus.out1_ready) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed vector table, reset/stats sequences and
// randomized traffic against a queue-based reference model.
module tb_stream_demux_1to2;
  import stream_demux_pkg::*;

  logic clk;
  logic rst_n;

  stream_demux_if #(.DATA_W(8)) bus ();

`ifdef STREAM_DEMUX_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  stream_demux_1to2 #(
    .DATA_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: per-port queues of beats the DUT should be presenting.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         lock;   // -1: between packets, else locked port
  int         hs0;
  int         hs1;

  task automatic model_clear();
    q0.delete();
    q1.delete();
    lock = -1;
    hs0  = 0;
    hs1  = 0;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] d, input logic last,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = d;
    bus.in_last    = last;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       last;
    logic       r0;
    logic       r1;
    logic       rdy;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       idle;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic sel, input logic [7:0] d,
                              input logic last, input logic r0, input logic r1,
                              input logic rdy, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic idle);
    vec_t t;
    t.v = v; t.sel = sel; t.d = d; t.last = last; t.r0 = r0; t.r1 = r1;
    t.rdy = rdy; t.v0 = v0; t.d0 = d0; t.v1 = v1; t.d1 = d1; t.idle = idle;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    model_clear();

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst_v0", bus.out0_valid, 0);
    check("rst_v1", bus.out1_valid, 0);
    check("rst_l0", bus.out0_last, 0);
    check("rst_l1", bus.out1_last, 0);
    check("rst_d0", bus.out0_data, 0);
    check("rst_d1", bus.out1_data, 0);
    check("rst_fsm", dut.state_q == IDLE, 1);
`ifdef STREAM_DEMUX_STATS_EN
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // v sel data last r0 r1 | in_ready before edge | v0 d0 v1 d1 idle after edge
    vecs.push_back(mk(1, 1, 8'hA5, 1, 1, 1, 1, 0, 8'h00, 1, 8'hA5, 1)); // single beat
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h11, 0, 1, 1, 1, 1, 8'h11, 0, 8'h00, 0)); // packet lock
    vecs.push_back(mk(1, 1, 8'h22, 0, 1, 1, 1, 1, 8'h22, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 8'h33, 1, 1, 1, 1, 1, 8'h33, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h01, 1, 0, 1, 1, 1, 8'h01, 0, 8'h00, 1)); // backpressure
    vecs.push_back(mk(1, 0, 8'h02, 1, 0, 1, 0, 1, 8'h01, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h02, 1, 1, 1, 1, 1, 8'h02, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 8'h10, 1, 0, 1, 1, 1, 8'h10, 0, 8'h00, 1)); // independence
    vecs.push_back(mk(1, 1, 8'h20, 1, 0, 1, 1, 1, 8'h10, 1, 8'h20, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h10, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h00, 0, 8'h00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].last, vecs[i].r0, vecs[i].r1);
      #1;
      check($sformatf("vec%0d_in_ready", i), bus.in_ready, vecs[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out0_valid", i), bus.out0_valid, vecs[i].v0);
      if (vecs[i].v0) check($sformatf("vec%0d_out0_data", i), bus.out0_data, vecs[i].d0);
      check($sformatf("vec%0d_out1_valid", i), bus.out1_valid, vecs[i].v1);
      if (vecs[i].v1) check($sformatf("vec%0d_out1_data", i), bus.out1_data, vecs[i].d1);
      check($sformatf("vec%0d_fsm_idle", i), dut.state_q == IDLE, vecs[i].idle);
    end

    // Reset in the middle of a 4-beat packet to port 0.
    do_reset();
    drive(1, 0, 8'h31, 0, 0, 1);
    @(negedge clk);
    drive(1, 0, 8'h32, 0, 1, 1);
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0, 1);
    #1;
    check("midpkt_pre_v0", bus.out0_valid, 1);
    check("midpkt_pre_d0", bus.out0_data, 8'h32);
    rst_n = 1'b0;
    #1;
    check("midpkt_rst_v0", bus.out0_valid, 0);
    check("midpkt_rst_d0", bus.out0_data, 0);
    check("midpkt_rst_fsm", dut.state_q == IDLE, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive(1, 1, 8'h77, 1, 1, 1);
    @(posedge clk);
    #1;
    check("midpkt_after_v1", bus.out1_valid, 1);
    check("midpkt_after_d1", bus.out1_data, 8'h77);
    check("midpkt_after_v0", bus.out0_valid, 0);

`ifdef STREAM_DEMUX_STATS_EN
    // Counter wrap: 65536 handshakes on out0, 3 on out1.
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1, 0, i[7:0], 1, 1, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i[7:0], 1, 1, 1);
      @(negedge clk);
    end
    drive(0, 0, 8'h00, 0, 1, 1);
    @(negedge clk);
    check("stats_cnt0_wrap", cnt0, 16'h0000);
    check("stats_cnt1", cnt1, 16'h0003);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, sel, last, r0, r1, exp_rdy, tgt;
      logic [7:0] d;
      v    = ($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 1);
      d    = 8'($urandom);
      last = ($urandom_range(0, 2) == 0);
      r0   = ($urandom_range(0, 2) != 0);
      r1   = ($urandom_range(0, 3) != 0);
      drive(v, sel, d, last, r0, r1);
      #1;
      tgt     = (lock < 0) ? sel : lock[0];
      exp_rdy = tgt ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
      check("rand_in_ready", bus.in_ready, exp_rdy);
      check("rand_out0_valid", bus.out0_valid, q0.size() != 0);
      check("rand_out1_valid", bus.out1_valid, q1.size() != 0);
      if (q0.size() != 0) check("rand_out0_beat", {bus.out0_last, bus.out0_data}, q0[0]);
      if (q1.size() != 0) check("rand_out1_beat", {bus.out1_last, bus.out1_data}, q1[0]);
`ifdef STREAM_DEMUX_STATS_EN
      check("rand_cnt0", cnt0, hs0 % 65536);
      check("rand_cnt1", cnt1, hs1 % 65536);
`endif
      if (q0.size() != 0 && r0) begin void'(q0.pop_front()); hs0++; end
      if (q1.size() != 0 && r1) begin void'(q1.pop_front()); hs1++; end
      if (v && exp_rdy) begin
        if (tgt) q1.push_back({last, d});
        else     q0.push_back({last, d});
        if (lock < 0 && !last) lock = tgt ? 1 : 0;
        else if (lock >= 0 && last) lock = -1;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-005 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-006 SHALL have port in_last, input, 1, final beat of packet.
REQ-007 SHALL have port in_sel, input, 1, destination port (0 = out0, 1 = out1), sampled on first beat of a packet only.
REQ-008 SHALL have port in_ready, output, 1, upstream may transfer this cycle.
REQ-009 SHALL have ports outN_valid, outN_data, outN_last, output, 1/DATA_W/1, registered downstream beat for N in {0,1}.
REQ-010 SHALL have port outN_ready, input, 1, downstream acceptance for N in {0,1}.

Function
REQ-011 Accept SHALL occur when in_valid && in_ready; outN handshake SHALL occur when outN_valid && outN_ready.
REQ-012 FSM SHALL have states IDLE, LOCK0, LOCK1. Target port: in_sel in IDLE, N in LOCKN.
REQ-013 IDLE: an accepted beat with in_last=0 SHALL go to LOCK<in_sel>. With in_last=1, the FSM SHALL stay in IDLE.
REQ-014 LOCKN: in_sel SHALL be ignored and every accepted beat routed to port N. An accepted beat with in_last=1 SHALL return the FSM to IDLE.
REQ-015 in_ready SHALL equal !target_valid || target_ready (combinational). No upstream acceptance path SHALL exist other than this.
REQ-016 An accepted beat SHALL appear on the target port's outputs on the following cycle (latency 1). The non-target port SHALL be untouched.
REQ-017 A same-cycle drain and load on one port SHALL keep outN_valid=1 with the new beat. A drain without a load SHALL clear outN_valid.
REQ-018 outN_data and outN_last SHALL be held stable while outN_valid && !outN_ready.
REQ-019 Each port SHALL drain independently. A stall on one port SHALL not block traffic targeted at the other.
REQ-020 Beat order within a port SHALL be preserved. No beat SHALL be dropped or duplicated.

Reset
REQ-021 While rst_n=0, the FSM SHALL be in IDLE and out0_valid, out1_valid, out0_last, out1_last SHALL be 0.
REQ-022 While rst_n=0, out0_data and out1_data SHALL be 0, and any statistics counters SHALL be 0.
REQ-023 Reset asserted mid-packet SHALL discard the partial packet and held beats. The first accepted beat after release SHALL be treated as a packet start.

Configuration
REQ-024 With macro STREAM_DEMUX_STATS_EN defined, the block SHALL add 16-bit outputs cnt0 and cnt1. Each SHALL increment on every outN handshake and wrap 0xFFFF->0x0000.
REQ-025 Without STREAM_DEMUX_STATS_EN, the block SHALL have no counter ports or counter logic. All other behaviour SHALL be identical.

Structure
REQ-026 Package stream_demux_pkg SHALL hold the FSM state enum typedef (IDLE, LOCK0, LOCK1) and constant CNT_W=16.
REQ-027 A sub-module stream_demux_out_reg SHALL implement one output register slice (valid/data/last, load/drain rules of REQ-016..018). It SHALL be instantiated twice.

Verification
REQ-028 Single beat: in_sel=1, data 0xA5, last=1, out1_ready=1. Response: out1_valid=1 with 0xA5 next cycle; out0_valid stays 0; FSM in IDLE.
REQ-029 Packet lock: beats 0x11, 0x22, 0x33 (last on 0x33) with in_sel=0,1,0. Response: all three arrive on out0 in order; nothing on out1; FSM returns to IDLE after 0x33.
REQ-030 Backpressure: out0_ready=0, two single-beat packets 0x01, 0x02 to port 0. Response: 0x01 held stable on out0 and in_ready=0; 0x02 accepted in the same cycle out0_ready rises; both delivered.
REQ-031 Independence: out0 stalled holding 0x10, then a beat 0x20 with in_sel=1. Response: in_ready=1, 0x20 delivered on out1, out0 still holds 0x10.
REQ-032 Reset mid-packet: rst_n low after the 2nd beat of a 4-beat packet to port 0. Response: valids 0 immediately. After release, a beat with in_sel=1 is delivered on out1.
REQ-033 Stats (STREAM_DEMUX_STATS_EN): 65536 handshakes on out0, 3 on out1. Response: cnt0=0x0000, cnt1=0x0003.
